// File: rtl/cache_miss_handler_pkg.sv
// Shared constants and types for the 2-way cache miss path.
// Line addresses are always built here so that every pmem request is line-aligned.
package cache_miss_handler_pkg;
  localparam int TAG_W  = 24;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 5;
  localparam int LINE_W = 256;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, WRITEBACK, FETCH, INSTALL, DONE} mh_state_e;
  typedef enum logic {WAY_LEFT = 1'b0, WAY_RIGHT = 1'b1} way_e;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_miss_handler_lru_array.sv
// Per-set LRU bit storage: combinational read, synchronous write, cleared on reset.
// A stored 0 names the left way as victim, 1 names the right way.
module lru_array #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_val,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_val
);
  logic [(1<<IDX_W)-1:0] lru_q, lru_d;

  always_comb begin
    lru_d = lru_q;
    if (we) lru_d[wr_idx] = wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) lru_q <= '0;
    else     lru_q <= lru_d;
  end

  assign rd_val = lru_q[rd_idx];
endmodule

// File: rtl/cache_miss_handler.sv
// Miss handler for the 2-way cache: victim choice, dirty writeback, line fetch, install.
// Owns the LRU bits and updates them on lookup hits while idle.
module cache_miss_handler
  import cache_miss_handler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              access_valid,
  input  logic              miss_req,
  input  logic              hit_left,
  input  logic              hit_right,
  input  logic [TAG_W-1:0]  tag_left,
  input  logic [TAG_W-1:0]  tag_right,
  input  logic              dirty_left,
  input  logic              dirty_right,
  input  logic [LINE_W-1:0] data_left,
  input  logic [LINE_W-1:0] data_right,
  output logic              fill_we_left,
  output logic              fill_we_right,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [LINE_W-1:0] fill_data,
  output logic              miss_done,
  output logic              busy,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  mh_state_e         state_q, state_d;
  way_e              victim_q, victim_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [LINE_W-1:0] vdata_q, vdata_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic              unused_off;
  logic              lru_rd, lru_we, lru_wr_val;
  logic [IDX_W-1:0]  lru_wr_idx;
  way_e              victim_sel;

  assign addr_tag   = addr[ADDR_W-1 -: TAG_W];
  assign addr_idx   = addr[OFF_W +: IDX_W];
  assign unused_off = ^addr[OFF_W-1:0];
  assign victim_sel = way_e'(lru_rd);

  lru_array #(.IDX_W(IDX_W)) u_lru (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (addr_idx),
    .rd_val (lru_rd),
    .we     (lru_we),
    .wr_idx (lru_wr_idx),
    .wr_val (lru_wr_val)
  );

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    tag_d         = tag_q;
    idx_d         = idx_q;
    vtag_d        = vtag_q;
    vdata_d       = vdata_q;
    line_d        = line_q;
    lru_we        = 1'b0;
    lru_wr_idx    = addr_idx;
    lru_wr_val    = 1'b0;
    fill_we_left  = 1'b0;
    fill_we_right = 1'b0;
    fill_tag      = '0;
    fill_data     = '0;
    miss_done     = 1'b0;
    busy          = 1'b1;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = '0;
    pmem_wdata    = '0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        // A miss outranks any hit flags presented in the same cycle.
        if (miss_req) begin
          tag_d    = addr_tag;
          idx_d    = addr_idx;
          victim_d = victim_sel;
          vtag_d   = (victim_sel == WAY_RIGHT) ? tag_right  : tag_left;
          vdata_d  = (victim_sel == WAY_RIGHT) ? data_right : data_left;
          state_d  = ((victim_sel == WAY_RIGHT) ? dirty_right : dirty_left) ? WRITEBACK : FETCH;
        end else if (access_valid && (hit_left || hit_right)) begin
          lru_we     = 1'b1;
          lru_wr_val = hit_left;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(vtag_q, idx_q);
        pmem_wdata   = vdata_q;
        if (pmem_resp) state_d = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(tag_q, idx_q);
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = INSTALL;
        end
      end
      INSTALL: begin
        fill_we_left  = (victim_q == WAY_LEFT);
        fill_we_right = (victim_q == WAY_RIGHT);
        fill_tag      = tag_q;
        fill_data     = line_q;
        lru_we        = 1'b1;
        lru_wr_idx    = idx_q;
        lru_wr_val    = (victim_q == WAY_LEFT);
        state_d       = DONE;
      end
      DONE: begin
        miss_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= WAY_LEFT;
      tag_q    <= '0;
      idx_q    <= '0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      vtag_q   <= vtag_d;
      vdata_q  <= vdata_d;
      line_q   <= line_d;
    end
  end
endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboard bench for cache_miss_handler: directed misses/hits push expected events,
// a negedge monitor pops and compares them as the DUT presents pmem, fill and done events.
module tb_cache_miss_handler;
  import cache_miss_handler_pkg::*;

  localparam int K_WR = 0, K_RD = 1, K_FILL = 2, K_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              access_valid = 1'b0, miss_req = 1'b0;
  logic              hit_left = 1'b0, hit_right = 1'b0;
  logic [TAG_W-1:0]  tag_left = '0, tag_right = '0;
  logic              dirty_left = 1'b0, dirty_right = 1'b0;
  logic [LINE_W-1:0] data_left = '0, data_right = '0;
  logic              fill_we_left, fill_we_right, miss_done, busy;
  logic [TAG_W-1:0]  fill_tag;
  logic [LINE_W-1:0] fill_data;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  cache_miss_handler dut (
    .clk(clk), .rst(rst), .addr(addr), .access_valid(access_valid), .miss_req(miss_req),
    .hit_left(hit_left), .hit_right(hit_right), .tag_left(tag_left), .tag_right(tag_right),
    .dirty_left(dirty_left), .dirty_right(dirty_right), .data_left(data_left),
    .data_right(data_right), .fill_we_left(fill_we_left), .fill_we_right(fill_we_right),
    .fill_tag(fill_tag), .fill_data(fill_data), .miss_done(miss_done), .busy(busy),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              way;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   jitter   = 1'b0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic take(input int kind, output exp_t e, output bit ok);
    n_checks++;
    ok = 1'b0;
    e  = '{default: '0};
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected no event", kind);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        n_fail++;
        $display("FAIL event_order: got kind %0d expected kind %0d", kind, e.kind);
      end else ok = 1'b1;
    end
  endtask

  logic              wr_prev = 1'b0, rd_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;
  logic [LINE_W-1:0] wdata_prev = '0;

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      if (pmem_read || pmem_write) chk("rd_wr_exclusive", pmem_read & pmem_write, 0);
      if (pmem_write && !wr_prev) begin
        take(K_WR, e, ok);
        if (ok) begin
          chk("wb_addr", pmem_address, e.addr);
          chk("wb_data", pmem_wdata, e.data);
        end
      end
      if (pmem_write && wr_prev) begin
        chk("wb_addr_stable", pmem_address, addr_prev);
        chk("wb_data_stable", pmem_wdata, wdata_prev);
      end
      if (pmem_read && !rd_prev) begin
        take(K_RD, e, ok);
        if (ok) chk("rd_addr", pmem_address, e.addr);
      end
      if (pmem_read && rd_prev) chk("rd_addr_stable", pmem_address, addr_prev);
      if (fill_we_left || fill_we_right) begin
        take(K_FILL, e, ok);
        chk("fill_onehot", fill_we_left & fill_we_right, 0);
        if (ok) begin
          chk("fill_way", fill_we_right, e.way);
          chk("fill_tag", fill_tag, e.tag);
          chk("fill_data", fill_data, e.data);
        end
      end
      if (miss_done) take(K_DONE, e, ok);
    end
    wr_prev    <= pmem_write;
    rd_prev    <= pmem_read;
    addr_prev  <= pmem_address;
    wdata_prev <= pmem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                      input logic [TAG_W-1:0] t, input logic w);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.tag = t; e.way = w;
    sb.push_back(e);
  endtask

  // Misses use a non-zero offset so the line-alignment of pmem_address is exercised.
  task automatic issue_miss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
    addr = {t, i, 5'h0C};
    access_valid = 1'b1;
    miss_req = 1'b1;
    tick();
    access_valid = 1'b0;
    miss_req = 1'b0;
  endtask

  task automatic serve(input int dly, input logic [LINE_W-1:0] rd);
    int n = 0;
    while (!(pmem_read || pmem_write) && n < 50) begin
      tick();
      n++;
    end
    chk("pmem_req_seen", (n < 50), 1);
    for (int k = 1; k < dly; k++) begin
      if (jitter) miss_req = ~miss_req;
      tick();
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (miss_done) break;
      n++;
    end
    chk("miss_done_seen", (n < 20), 1);
  endtask

  task automatic hit(input logic [IDX_W-1:0] i, input logic l, input logic r, input logic av);
    addr = {{TAG_W{1'b0}}, i, 5'h00};
    access_valid = av;
    hit_left = l;
    hit_right = r;
    tick();
    access_valid = 1'b0;
    hit_left = 1'b0;
    hit_right = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] rd_a, rd_b, wb_r;
    rd_a = {32{8'h5A}};
    rd_b = {32{8'hC3}};
    wb_r = {8{32'hDEADBEEF}};

    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_fill_we", {fill_we_left, fill_we_right}, 0);
    chk("rst_miss_done", miss_done, 0);
    chk("rst_lru", dut.u_lru.lru_q, 0);
    rst = 1'b0;
    tick();

    // pmem_resp while idle must not start anything
    pmem_resp = 1'b1; pmem_rdata = rd_b;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    chk("idle_resp_busy", busy, 0);
    chk("idle_resp_read", pmem_read, 0);

    // clean miss: set 3, left victim
    tag_left = 24'h123456; dirty_left = 1'b0; data_left = {8{32'h0BAD0BAD}};
    push(K_RD, 32'hABCDEF60, '0, '0, 1'b0);
    push(K_FILL, '0, rd_a, 24'hABCDEF, 1'b0);
    push(K_DONE, '0, '0, '0, 1'b0);
    issue_miss(24'hABCDEF, 3'd3);
    chk("clean_busy", busy, 1);
    serve(4, rd_a);
    wait_done();
    tick();
    chk("clean_idle", busy, 0);
    chk("clean_lru3", dut.u_lru.lru_q[3], 1);

    // LRU on hits
    hit(3'd2, 1'b1, 1'b0, 1'b1);
    chk("hit_left_lru2", dut.u_lru.lru_q[2], 1);
    hit(3'd2, 1'b0, 1'b1, 1'b1);
    chk("hit_right_lru2", dut.u_lru.lru_q[2], 0);
    hit(3'd2, 1'b1, 1'b1, 1'b1);
    chk("hit_both_lru2", dut.u_lru.lru_q[2], 1);
    hit(3'd6, 1'b1, 1'b0, 1'b0);
    chk("hit_noaccess_lru6", dut.u_lru.lru_q[6], 0);
    chk("hit_busy", busy, 0);

    // dirty miss: set 5, right victim, inputs disturbed while busy
    hit(3'd5, 1'b1, 1'b0, 1'b1);
    chk("pre_dirty_lru5", dut.u_lru.lru_q[5], 1);
    tag_right = 24'h111111; dirty_right = 1'b1; data_right = wb_r;
    push(K_WR, 32'h111111A0, wb_r, '0, 1'b0);
    push(K_RD, 32'h222222A0, '0, '0, 1'b0);
    push(K_FILL, '0, rd_b, 24'h222222, 1'b1);
    push(K_DONE, '0, '0, '0, 1'b0);
    issue_miss(24'h222222, 3'd5);
    addr = {24'h444444, 3'd6, 5'h00};
    access_valid = 1'b1; miss_req = 1'b1; jitter = 1'b1;
    tag_right = 24'hFFFFFF; data_right = '0; dirty_right = 1'b0;
    serve(3, '0);
    serve(2, rd_b);
    jitter = 1'b0; miss_req = 1'b0; access_valid = 1'b0;
    wait_done();
    tick();
    chk("dirty_lru5", dut.u_lru.lru_q[5], 0);
    chk("dirty_lru6", dut.u_lru.lru_q[6], 0);

    // reset during fetch: request drops, late response ignored, LRU cleared
    dirty_left = 1'b0;
    push(K_RD, 32'h33333320, '0, '0, 1'b0);
    issue_miss(24'h333333, 3'd1);
    tick(); tick();
    chk("pre_rst_read", pmem_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_read", pmem_read, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_lru", dut.u_lru.lru_q, 0);
    pmem_resp = 1'b1; pmem_rdata = rd_a;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick(); tick();
    chk("late_resp_busy", busy, 0);

    // back-to-back clean misses to set 0 and set 7
    push(K_RD, 32'h000AAA00, '0, '0, 1'b0);
    push(K_FILL, '0, rd_a, 24'h000AAA, 1'b0);
    push(K_DONE, '0, '0, '0, 1'b0);
    push(K_RD, 32'h0BBBBBE0, '0, '0, 1'b0);
    push(K_FILL, '0, rd_b, 24'h0BBBBB, 1'b0);
    push(K_DONE, '0, '0, '0, 1'b0);
    issue_miss(24'h000AAA, 3'd0);
    serve(2, rd_a);
    wait_done();
    tick();
    issue_miss(24'h0BBBBB, 3'd7);
    chk("b2b_read_next", pmem_read, 1);
    serve(1, rd_b);
    wait_done();
    tick(); tick();
    chk("b2b_lru0", dut.u_lru.lru_q[0], 1);
    chk("b2b_lru7", dut.u_lru.lru_q[7], 1);
    chk("b2b_idle", busy, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Miss-side counterpart of the 2-way lookup/hit path.
- When lookup reports a miss, the block picks a victim way from a per-set LRU bit and writes the victim line back to physical memory if it is dirty.
- It then fetches the new line and installs data, tag and valid into the victim way.
- It owns the LRU array and updates it on hits reported by the lookup path. It sits between the cache datapath/way arrays and the pmem interface.

Parameters:
TAG_W, 24, tag width in bits
IDX_W, 3, set index width (2^IDX_W sets)
OFF_W, 5, byte-offset width (line = 2^OFF_W bytes)
LINE_W, 256, line width in bits (= 8 * 2^OFF_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  TAG_W+IDX_W+OFF_W  CPU access address, valid with access_valid/miss_req
access_valid  in  1  CPU access present this cycle
miss_req  in  1  lookup missed (access_valid and neither way hit)
hit_left  in  1  left way hit
hit_right  in  1  right way hit
tag_left  in  TAG_W  stored tag of left way, indexed set
tag_right  in  TAG_W  stored tag of right way, indexed set
dirty_left  in  1  dirty bit of left way, indexed set
dirty_right  in  1  dirty bit of right way, indexed set
data_left  in  LINE_W  line data of left way, indexed set
data_right  in  LINE_W  line data of right way, indexed set
fill_we_left  out  1  write data/tag, set valid, clear dirty in left way
fill_we_right  out  1  same for right way
fill_tag  out  TAG_W  tag to install
fill_data  out  LINE_W  line to install
miss_done  out  1  one-cycle pulse: line installed, lookup may retry
busy  out  1  handler not IDLE
pmem_read  out  1  line read request
pmem_write  out  1  line write request
pmem_address  out  TAG_W+IDX_W+OFF_W  line-aligned address (offset bits 0)
pmem_wdata  out  LINE_W  writeback data
pmem_rdata  in  LINE_W  fetched line, valid with pmem_resp
pmem_resp  in  1  pmem transaction complete

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; all LRU bits are 0 (victim = left).
  - All outputs are 0, including pmem_read, pmem_write, fill_we_*, miss_done and busy.
  - Reset mid-transaction aborts it. pmem requests drop the cycle after reset, and a late pmem_resp is ignored.
- LRU encoding: lru[set]=0 means left is victim; lru[set]=1 means right is victim.
- LRU update on hits, IDLE only, with access_valid=1:
  - hit_left sets lru[set] to 1.
  - hit_right sets lru[set] to 0.
  - If both are asserted, left has priority.
  - If miss_req is also asserted, the miss wins and the hit is ignored.
- State IDLE:
  - On miss_req=1, latch addr tag/index, latch victim = lru[set], and latch the victim's tag, data and dirty bit.
  - Go to WRITEBACK if the victim is dirty, else FETCH.
  - pmem_resp is ignored in IDLE.
- State WRITEBACK:
  - pmem_write=1, pmem_address={victim_tag, index, 0}, pmem_wdata=latched victim data.
  - Requests are held stable until pmem_resp=1, then go to FETCH.
- State FETCH:
  - pmem_read=1, pmem_address={miss_tag, index, 0}, held until pmem_resp.
  - On pmem_resp, latch pmem_rdata and go to INSTALL.
- State INSTALL (1 cycle):
  - Assert fill_we_<victim>=1 with fill_tag=miss_tag and fill_data=latched line.
  - Set lru[set] = ~victim, so the installed way becomes MRU. Go to DONE.
- State DONE (1 cycle): miss_done=1, go to IDLE.
- Latency, clean miss: miss_req cycle, then FETCH for N pmem cycles, then INSTALL, then DONE. miss_done comes 2 cycles after the pmem_resp edge.
- pmem_read and pmem_write are never asserted together, and are never asserted outside FETCH/WRITEBACK.
- busy=1 in every non-IDLE state. miss_req while busy is ignored.
- The latched victim/addr is used throughout; input changes during a miss have no effect.
- Back-to-back misses: a new miss_req may be accepted the cycle after DONE.

Decomposition:
- Shared cache package holds:
  - constants TAG_W, IDX_W, OFF_W, LINE_W;
  - the handler state enum {IDLE, WRITEBACK, FETCH, INSTALL, DONE};
  - a way-select typedef (1 bit: 0=left, 1=right).
- One sub-module is natural: lru_array (2^IDX_W x 1 bit, synchronous write, combinational read, cleared on rst).

Test Plan:
- Clean miss:
  - Stimulus: lru[3]=0, dirty_left=0, miss_req with addr tag 0xABCDEF, index 3; pmem_resp after 4 cycles with rdata=0x5A.. pattern.
  - Response: pmem_read=1 at address 0xABCDEF60. fill_we_left=1 with that tag/data comes 1 cycle after resp, then miss_done; lru[3]=1 after.
- Dirty miss:
  - Stimulus: lru[5]=1, dirty_right=1, tag_right=0x111111, miss on tag 0x222222, index 5.
  - Response: first pmem_write at 0x111111A0 with data_right, then pmem_read at 0x222222A0. fill_we_right, then lru[5]=0.
- LRU on hits: hit_left at set 2 sets lru[2]=1; hit_right at set 2 then sets lru[2]=0. No pmem activity and no miss_done.
- Reset mid-fetch:
  - Stimulus: rst=1 during FETCH, then pmem_resp=1.
  - Response: state IDLE, pmem_read=0 next cycle, no fill_we, no miss_done, all LRU bits 0.
- Ignored inputs:
  - Stimulus: pmem_resp=1 in IDLE; miss_req toggling while busy.
  - Response: no state change and no extra transaction. Exactly one miss_done per accepted miss.
- Back-to-back: two clean misses, one to set 0 then one to set 7.
  - Response: second pmem_read is asserted the cycle after the first DONE's IDLE accept. Both ways installed correctly.
